// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the MEM-stage data-cache controller.
//   word_t          : architectural data word
//   memctrl_state_t : request FSM encoding (IDLE -> REQ -> DONE)
package mem_stage_ctrl_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memctrl_state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request/hit bus between the MEM stage and the dcache.
//   dmemREN / dmemWEN : read / write request (MEM stage -> dcache)
//   dmemaddr          : byte address of the request
//   dmemstore         : store data
//   dhit              : dcache completes the current request
//   dmemload          : read data, valid with dhit
// master = MEM stage (initiator), slave = dcache.
interface mem_stage_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );

endinterface

// File: rtl/mem_stage_ctrl_llsc_link_reg.sv
// LL/SC link register. Holds the word address of the last load-linked and
// whether the reservation is still intact.
//   CLK, nRST    : clock, async active-low reset
//   set, set_tag : ll completed at word address set_tag
//   clr          : own sc/sw completed that kills the reservation
//   snoop_inv, snoop_tag : coherence invalidate at word address snoop_tag
//   cmp_tag      : word address to test against the reservation
//   link_valid, link_addr : current reservation
//   match        : reservation valid and equal to cmp_tag
module mem_stage_ctrl_llsc_link_reg #(
  parameter int unsigned TAG_W = 30
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             set,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clr,
  input  logic             snoop_inv,
  input  logic [TAG_W-1:0] snoop_tag,
  input  logic [TAG_W-1:0] cmp_tag,
  output logic             link_valid,
  output logic [TAG_W-1:0] link_addr,
  output logic             match
);

  logic             link_valid_q, link_valid_d;
  logic [TAG_W-1:0] link_addr_q, link_addr_d;

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (set) begin
      // A same-cycle invalidate of the address being linked wins.
      link_addr_d  = set_tag;
      link_valid_d = ~(snoop_inv & (snoop_tag == set_tag));
    end else if (clr | (snoop_inv & (snoop_tag == link_addr_q))) begin
      link_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign link_valid = link_valid_q;
  assign link_addr  = link_addr_q;
  assign match      = link_valid_q & (link_addr_q == cmp_tag);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage initiator for the dcache request/hit protocol. Issues one
// request per EX/MEM operation, stalls the pipe until dhit, captures load
// data (or the sc result) for MEM/WB, resolves LL/SC through the link
// register and makes halt sticky once memory is quiet.
//   CLK, nRST          : clock, async active-low reset
//   op_valid           : live instruction in EX/MEM
//   memRead/memWrite   : lw,ll / sw,sc
//   ll, sc             : load-linked / store-conditional qualifiers
//   halt_in            : halt instruction in MEM
//   addr, store_data   : effective address and store data
//   advance            : pipeline latches update this cycle
//   snoop_inv/_addr    : coherence invalidate
//   dbus (master)      : dcache request/hit bus
//   mem_stall          : freeze IF..MEM
//   load_data          : to MEM/WB (sc: {0, sc_result})
//   halt_out           : sticky halt to MEM/WB
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              op_valid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              ll,
  input  logic              sc,
  input  logic              halt_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              advance,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  mem_stage_ctrl_if.master  dbus,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              halt_out
);

  localparam int unsigned TAG_W = ADDR_W - 2;

  memctrl_state_t    state_q, state_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              halt_out_q, halt_out_d;

  logic             link_valid;
  logic [TAG_W-1:0] link_addr;
  logic             link_match;
  logic             link_set;
  logic             link_clr;

  logic ren, wen, stall, xfer;
  logic mem_op, sc_fail;

  logic unused_snoop_lsbs;
  assign unused_snoop_lsbs = ^snoop_addr[1:0];

  // nRST term keeps requests low while reset is held with a live op.
  assign mem_op  = nRST & op_valid & (memRead | memWrite) & ~halt_out_q;
  assign sc_fail = sc & memWrite & ~link_match;

  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    halt_out_d  = halt_out_q | (op_valid & halt_in & (state_q != REQ));
    ren         = 1'b0;
    wen         = 1'b0;
    stall       = 1'b0;
    xfer        = 1'b0;
    link_set    = 1'b0;
    link_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (sc_fail) begin
            load_data_d = '0;
            state_d     = DONE;
          end else begin
            ren = memRead;
            wen = memWrite;
            if (dbus.dhit) begin
              xfer    = 1'b1;
              state_d = DONE;
            end else begin
              stall   = 1'b1;
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        // Issued request is held unchanged until dhit: neither a halt
        // latched in the issue cycle nor a snoop may withdraw it.
        ren = memRead;
        wen = memWrite;
        if (dbus.dhit) begin
          xfer    = 1'b1;
          state_d = DONE;
        end else begin
          stall = 1'b1;
        end
      end
      DONE: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      if (memRead)  load_data_d = dbus.dmemload;
      else if (sc)  load_data_d = DATA_W'(1);
      link_set = memRead & ll;
      link_clr = memWrite & (sc | link_match);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      load_data_q <= '0;
      halt_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      halt_out_q  <= halt_out_d;
    end
  end

  mem_stage_ctrl_llsc_link_reg #(
    .TAG_W (TAG_W)
  ) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (link_set),
    .set_tag    (addr[ADDR_W-1:2]),
    .clr        (link_clr),
    .snoop_inv  (snoop_inv),
    .snoop_tag  (snoop_addr[ADDR_W-1:2]),
    .cmp_tag    (addr[ADDR_W-1:2]),
    .link_valid (link_valid),
    .link_addr  (link_addr),
    .match      (link_match)
  );

  assign dbus.dmemREN   = ren;
  assign dbus.dmemWEN   = wen;
  assign dbus.dmemaddr  = addr;
  assign dbus.dmemstore = store_data;
  assign mem_stall      = stall;
  assign load_data      = load_data_q;
  assign halt_out       = halt_out_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        op_valid, memRead, memWrite, ll, sc, halt_in;
  logic [31:0] addr, store_data, snoop_addr;
  logic        advance, snoop_inv;
  logic        mem_stall, halt_out;
  logic [31:0] load_data;

  int vectors = 0;
  int miscompares = 0;

  mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .op_valid   (op_valid),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .ll         (ll),
    .sc         (sc),
    .halt_in    (halt_in),
    .addr       (addr),
    .store_data (store_data),
    .advance    (advance),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .dbus       (bus),
    .mem_stall  (mem_stall),
    .load_data  (load_data),
    .halt_out   (halt_out)
  );

  always #5 CLK = ~CLK;

  // advance must never coincide with a stall
  always @(negedge CLK) begin
    if (nRST) begin
      assert (!(advance && mem_stall)) else begin
        miscompares++;
        $error("FAIL adv_in_stall: observed=1 expected=0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic op(input logic v, input logic rd, input logic wr, input logic l,
                    input logic s, input logic [31:0] a, input logic [31:0] d);
    op_valid = v; memRead = rd; memWrite = wr; ll = l; sc = s;
    addr = a; store_data = d;
  endtask

  initial begin
    nRST = 1'b0; halt_in = 1'b0; advance = 1'b0; snoop_inv = 1'b0; snoop_addr = '0;
    op(0, 0, 0, 0, 0, 32'h0, 32'h0);
    bus.dhit = 1'b0; bus.dmemload = '0;
    #2;
    chk("rst_ren",   32'(bus.dmemREN), 0);
    chk("rst_wen",   32'(bus.dmemWEN), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_load",  load_data, 0);
    chk("rst_halt",  32'(halt_out), 0);
    chk("rst_link",  32'(dut.link_valid), 0);
    @(negedge CLK) nRST = 1'b1;
    step();

    // lw 0x40, dhit on the fourth request cycle
    op(1, 1, 0, 0, 0, 32'h40, 32'h0); #1;
    chk("lw_addr", bus.dmemaddr, 32'h40);
    chk("lw_ren_c0", 32'(bus.dmemREN), 1);
    chk("lw_wen_c0", 32'(bus.dmemWEN), 0);
    chk("lw_stall_c0", 32'(mem_stall), 1);
    step();
    for (int i = 1; i < 3; i++) begin
      #1;
      chk("lw_ren_wait", 32'(bus.dmemREN), 1);
      chk("lw_stall_wait", 32'(mem_stall), 1);
      step();
    end
    bus.dhit = 1'b1; bus.dmemload = 32'hDEAD_BEEF; #1;
    chk("lw_ren_hit", 32'(bus.dmemREN), 1);
    chk("lw_stall_hit", 32'(mem_stall), 0);
    step();
    bus.dhit = 1'b0; bus.dmemload = '0; #1;
    chk("lw_ren_done", 32'(bus.dmemREN), 0);
    chk("lw_stall_done", 32'(mem_stall), 0);
    chk("lw_load", load_data, 32'hDEAD_BEEF);
    advance = 1'b1;
    step();
    advance = 1'b0; op(0, 0, 0, 0, 0, 32'h0, 32'h0);

    // sw 0x80 with zero-latency dhit
    op(1, 0, 1, 0, 0, 32'h80, 32'h1234); bus.dhit = 1'b1; #1;
    chk("sw_wen", 32'(bus.dmemWEN), 1);
    chk("sw_ren", 32'(bus.dmemREN), 0);
    chk("sw_stall", 32'(mem_stall), 0);
    chk("sw_store", bus.dmemstore, 32'h1234);
    step();
    bus.dhit = 1'b0; #1;
    chk("sw_wen_done", 32'(bus.dmemWEN), 0);
    chk("sw_state_done", 32'(dut.state_q), 32'(DONE));
    advance = 1'b1;
    step();
    advance = 1'b0; op(0, 0, 0, 0, 0, 32'h0, 32'h0); #1;
    chk("sw_state_idle", 32'(dut.state_q), 32'(IDLE));

    // ll 0x100 then successful sc 0x100
    op(1, 1, 0, 1, 0, 32'h100, 32'h0); bus.dhit = 1'b1; bus.dmemload = 32'h77; #1;
    chk("ll_ren", 32'(bus.dmemREN), 1);
    step();
    bus.dhit = 1'b0; advance = 1'b1; #1;
    chk("ll_load", load_data, 32'h77);
    chk("ll_link", 32'(dut.link_valid), 1);
    step();
    advance = 1'b0;
    op(1, 0, 1, 0, 1, 32'h100, 32'h5); #1;
    chk("sc_wen", 32'(bus.dmemWEN), 1);
    chk("sc_stall", 32'(mem_stall), 1);
    step();
    bus.dhit = 1'b1; #1;
    chk("sc_wen_req", 32'(bus.dmemWEN), 1);
    chk("sc_stall_hit", 32'(mem_stall), 0);
    step();
    bus.dhit = 1'b0; advance = 1'b1; #1;
    chk("sc_load", load_data, 32'h1);
    chk("sc_link", 32'(dut.link_valid), 0);
    chk("sc_wen_done", 32'(bus.dmemWEN), 0);
    step();
    advance = 1'b0; op(0, 0, 0, 0, 0, 32'h0, 32'h0);

    // ll 0x100, snoop miss, snoop hit, failing sc
    op(1, 1, 0, 1, 0, 32'h100, 32'h0); bus.dhit = 1'b1; bus.dmemload = 32'h55; #1;
    step();
    bus.dhit = 1'b0; advance = 1'b1; #1;
    chk("ll2_link", 32'(dut.link_valid), 1);
    step();
    advance = 1'b0; op(0, 0, 0, 0, 0, 32'h0, 32'h0);
    snoop_inv = 1'b1; snoop_addr = 32'h104;
    step();
    snoop_inv = 1'b0; #1;
    chk("snoop_miss_link", 32'(dut.link_valid), 1);
    snoop_inv = 1'b1; snoop_addr = 32'h100;
    step();
    snoop_inv = 1'b0; #1;
    chk("snoop_hit_link", 32'(dut.link_valid), 0);
    op(1, 0, 1, 0, 1, 32'h100, 32'h9); #1;
    chk("scf_wen", 32'(bus.dmemWEN), 0);
    chk("scf_stall", 32'(mem_stall), 0);
    step();
    advance = 1'b1; #1;
    chk("scf_load", load_data, 32'h0);
    chk("scf_state", 32'(dut.state_q), 32'(DONE));
    step();
    advance = 1'b0; op(0, 0, 0, 0, 0, 32'h0, 32'h0);

    // snoop to the same address beats a same-cycle ll completion
    op(1, 1, 0, 1, 0, 32'h200, 32'h0); bus.dhit = 1'b1; bus.dmemload = 32'h11;
    snoop_inv = 1'b1; snoop_addr = 32'h200;
    step();
    bus.dhit = 1'b0; snoop_inv = 1'b0; advance = 1'b1; #1;
    chk("ll_snoop_link", 32'(dut.link_valid), 0);
    chk("ll_snoop_load", load_data, 32'h11);
    step();
    advance = 1'b0;

    // own sw to the linked word kills the reservation
    op(1, 1, 0, 1, 0, 32'h300, 32'h0); bus.dhit = 1'b1;
    step();
    bus.dhit = 1'b0; advance = 1'b1; #1;
    chk("ll3_link", 32'(dut.link_valid), 1);
    step();
    advance = 1'b0;
    op(1, 0, 1, 0, 0, 32'h300, 32'h1); bus.dhit = 1'b1;
    step();
    bus.dhit = 1'b0; advance = 1'b1; #1;
    chk("sw_link_clr", 32'(dut.link_valid), 0);
    step();
    advance = 1'b0; op(0, 0, 0, 0, 0, 32'h0, 32'h0);

    // reset while a request is outstanding
    op(1, 1, 0, 1, 0, 32'h100, 32'h0); bus.dhit = 1'b1;
    step();
    bus.dhit = 1'b0; advance = 1'b1;
    step();
    advance = 1'b0;
    op(1, 1, 0, 0, 0, 32'h40, 32'h0);
    step(); #1;
    chk("rq_ren", 32'(bus.dmemREN), 1);
    chk("rq_link", 32'(dut.link_valid), 1);
    nRST = 1'b0; #1;
    chk("rr_ren", 32'(bus.dmemREN), 0);
    chk("rr_wen", 32'(bus.dmemWEN), 0);
    chk("rr_stall", 32'(mem_stall), 0);
    chk("rr_link", 32'(dut.link_valid), 0);
    chk("rr_state", 32'(dut.state_q), 32'(IDLE));
    op(0, 0, 0, 0, 0, 32'h0, 32'h0); #2;
    nRST = 1'b1;
    step();

    // halt is sticky and blocks later requests
    op_valid = 1'b1; halt_in = 1'b1; #1;
    chk("halt_pre", 32'(halt_out), 0);
    step();
    op_valid = 1'b0; halt_in = 1'b0; #1;
    chk("halt_set", 32'(halt_out), 1);
    op(1, 1, 0, 0, 0, 32'h40, 32'h0); #1;
    chk("halt_ren", 32'(bus.dmemREN), 0);
    chk("halt_stall", 32'(mem_stall), 0);
    step(); #1;
    chk("halt_ren2", 32'(bus.dmemREN), 0);
    chk("halt_sticky", 32'(halt_out), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
